// File: rtl/fsm_mode_pkg.sv
// Shared types for the mode controller: operating modes, controller states
// and the saturating counter helper.
package fsm_mode_pkg;

  localparam int MODE_W  = 2;
  localparam int STATE_W = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_STBY  = 2'd1,
    MODE_RUN   = 2'd2,
    MODE_DEBUG = 2'd3
  } mode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LOCKED = 3'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fsm_mode_legal_chk.sv
// Combinational legality check for a requested mode change given the
// current mode and the debug enable.
module fsm_mode_legal_chk
  import fsm_mode_pkg::*;
(
  input  mode_e       cur_mode,
  input  logic [2:0]  req_mode,
  input  logic        dbg_en,
  output logic        legal
);

  logic [MODE_W-1:0] tgt;

  always_comb begin
    legal = 1'b0;
    tgt   = req_mode[MODE_W-1:0];
    // Codes 4..7 do not name a mode and are never legal
    if (!req_mode[2]) begin
      case (cur_mode)
        MODE_OFF:   legal = (tgt == MODE_OFF) || (tgt == MODE_STBY);
        MODE_STBY:  legal = (tgt != MODE_DEBUG) || dbg_en;
        MODE_RUN:   legal = (tgt == MODE_RUN) || (tgt == MODE_STBY);
        MODE_DEBUG: legal = (tgt == MODE_DEBUG) || (tgt == MODE_STBY);
        default:    legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fsm_mode_ctrl.sv
// Mode-change controller: accepts requests, checks legality, settles after a
// change, counts consecutive rejects and locks out at the limit.
//
// state  | meaning
// IDLE   | ready for a request
// CHECK  | captured request is evaluated (dbg_en sampled here)
// SETTLE | mode changed, waiting SETTLE_CYCLES before responding
// LOCKED | too many rejects; mode held OFF until reset
module fsm_mode_ctrl
  import fsm_mode_pkg::*;
#(
  parameter int REJECT_LIMIT  = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [2:0]       req_mode,
  input  logic             dbg_en,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_ok,
  output logic [MODE_W-1:0] mode,
  output logic             busy,
  output logic             locked,
  output logic [CNT_W-1:0] reject_cnt
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] rej_q, rej_d, rej_inc;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [2:0]       req_q, req_d;
  logic             rv_q, rv_d, rok_q, rok_d;
  logic             legal;

  fsm_mode_legal_chk u_legal_chk (
    .cur_mode (mode_q),
    .req_mode (req_q),
    .dbg_en   (dbg_en),
    .legal    (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_OFF;
      rej_q    <= '0;
      settle_q <= '0;
      req_q    <= '0;
      rv_q     <= 1'b0;
      rok_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rej_q    <= rej_d;
      settle_q <= settle_d;
      req_q    <= req_d;
      rv_q     <= rv_d;
      rok_q    <= rok_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rej_d    = rej_q;
    settle_d = settle_q;
    req_d    = req_q;
    rv_d     = 1'b0;
    rok_d    = 1'b0;
    rej_inc  = sat_inc(rej_q);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d   = req_mode;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (legal) begin
          mode_d   = mode_e'(req_q[MODE_W-1:0]);
          rej_d    = '0;
          settle_d = CNT_W'(SETTLE_CYCLES - 1);
          state_d  = ST_SETTLE;
        end else begin
          rej_d = rej_inc;
          rv_d  = 1'b1;
          if (rej_inc == CNT_W'(REJECT_LIMIT)) begin
            state_d = ST_LOCKED;
            mode_d  = MODE_OFF;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_IDLE;
          rv_d    = 1'b1;
          rok_d   = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_LOCKED: mode_d = MODE_OFF;
      default: begin
        state_d = ST_LOCKED;
        mode_d  = MODE_OFF;
      end
    endcase
  end

  // The state register already reads IDLE during reset, so gate ready on rst
  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign busy       = (state_q == ST_CHECK) || (state_q == ST_SETTLE);
  assign locked     = (state_q == ST_LOCKED);
  assign mode       = mode_q;
  assign reject_cnt = rej_q;
  assign resp_valid = rv_q;
  assign resp_ok    = rok_q;

endmodule

// File: tb/tb_fsm_mode_ctrl.sv
// Self-checking bench for fsm_mode_ctrl: directed vector table, corner-case
// sequences and randomized requests against a transaction-level model.
module tb_fsm_mode_ctrl;
  import fsm_mode_pkg::*;

  localparam int REJECT_LIMIT  = 3;
  localparam int SETTLE_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_mode;
  logic       dbg_en;
  logic       req_ready, resp_valid, resp_ok, busy, locked;
  logic [1:0] mode;
  logic [3:0] reject_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int m_mode, m_rej;

  fsm_mode_ctrl #(.REJECT_LIMIT(REJECT_LIMIT), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode), .dbg_en(dbg_en),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ok(resp_ok), .mode(mode),
    .busy(busy), .locked(locked), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] rm;
    bit         dbg;
    bit         ok;
    logic [1:0] md;
    logic [3:0] rj;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit model_legal(input int from, input int to, input bit dbg);
    if (to > 3) return 1'b0;
    if (to == from) return 1'b1;
    if (from < 3 && to < 3) return (from - to == 1) || (to - from == 1);
    if (from == 3) return to == 1;
    return (from == 1) && dbg;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_rej"}, reject_cnt, 0);
    chk({tag, "_rv"}, resp_valid, 0);
    chk({tag, "_rok"}, resp_ok, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_ready"}, req_ready, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_rv", resp_valid, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1);
    chk("mode_after_rst", mode, 0);
  endtask

  task automatic send_req(input logic [2:0] rm, input bit dbg_acc, input bit dbg_chk,
                          input bit exp_ok, input logic [1:0] exp_mode,
                          input logic [3:0] exp_rej, input bit exp_lock);
    int edges;
    int exp_lat;
    exp_lat = exp_ok ? 1 + SETTLE_CYCLES : 1;
    @(negedge clk);
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_mode  = rm;
    dbg_en    = dbg_acc;
    @(posedge clk); #1;
    req_valid = 1'($urandom_range(0, 1));
    req_mode  = 3'($urandom_range(0, 7));
    dbg_en    = dbg_chk;
    chk("busy_in_check", busy, 1);
    edges = 0;
    while (edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1 && exp_ok) chk("mode_at_settle", mode, exp_mode);
      if (resp_valid) break;
      req_valid = 1'($urandom_range(0, 1));
      req_mode  = 3'($urandom_range(0, 7));
    end
    req_valid = 1'b0;
    chk("resp_latency", edges, exp_lat);
    chk("resp_ok", resp_ok, exp_ok);
    chk("mode_after_resp", mode, exp_mode);
    chk("reject_cnt", reject_cnt, exp_rej);
    chk("locked", locked, exp_lock);
    chk("ready_after_resp", req_ready, !exp_lock);
    @(posedge clk); #1;
    chk("resp_pulse_width", resp_valid, 0);
  endtask

  initial begin
    logic [2:0] rm;
    bit da, dc, ok, lk;

    rst = 1'b1; req_valid = 1'b0; req_mode = 3'd0; dbg_en = 1'b0;

    //           rm   dbg  ok  mode rej
    vecs[0]  = '{3'd1, 1'b0, 1'b1, 2'd1, 4'd0};
    vecs[1]  = '{3'd3, 1'b0, 1'b0, 2'd1, 4'd1};
    vecs[2]  = '{3'd3, 1'b1, 1'b1, 2'd3, 4'd0};
    vecs[3]  = '{3'd2, 1'b1, 1'b0, 2'd3, 4'd1};
    vecs[4]  = '{3'd1, 1'b0, 1'b1, 2'd1, 4'd0};
    vecs[5]  = '{3'd2, 1'b0, 1'b1, 2'd2, 4'd0};
    vecs[6]  = '{3'd2, 1'b0, 1'b1, 2'd2, 4'd0};
    vecs[7]  = '{3'd0, 1'b1, 1'b0, 2'd2, 4'd1};
    vecs[8]  = '{3'd5, 1'b1, 1'b0, 2'd2, 4'd2};
    vecs[9]  = '{3'd1, 1'b0, 1'b1, 2'd1, 4'd0};
    vecs[10] = '{3'd0, 1'b0, 1'b1, 2'd0, 4'd0};
    vecs[11] = '{3'd7, 1'b1, 1'b0, 2'd0, 4'd1};

    do_reset();
    // dbg_en at accept is the inverse of the CHECK-cycle value; only the latter counts
    for (int i = 0; i < 12; i++)
      send_req(vecs[i].rm, !vecs[i].dbg, vecs[i].dbg, vecs[i].ok, vecs[i].md, vecs[i].rj, 1'b0);

    // Lockout after three illegal requests, persisting until reset
    do_reset();
    send_req(3'd6, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 1'b0);
    send_req(3'd6, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 1'b0);
    send_req(3'd6, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3, 1'b1);
    repeat (5) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_mode  = 3'd1;
      #1;
      chk("lock_hold_locked", locked, 1);
      chk("lock_hold_ready", req_ready, 0);
      chk("lock_hold_mode", mode, 0);
      chk("lock_hold_busy", busy, 0);
    end
    req_valid = 1'b0;

    // Reset during SETTLE aborts with no response
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_mode = 3'd1; dbg_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("settle_busy", busy, 1);
    chk("settle_mode", mode, 1);
    #2;
    do_reset();
    chk("abort_rej", reject_cnt, 0);

    // Unused state encoding recovers to LOCKED with mode OFF
    send_req(3'd1, 1'b0, 1'b0, 1'b1, 2'd1, 4'd0, 1'b0);
    @(negedge clk);
    force dut.state_q = state_e'(3'd5);
    #1;
    release dut.state_q;
    @(posedge clk); #1;
    chk("bad_state_locked", locked, 1);
    chk("bad_state_mode", mode, 0);
    chk("bad_state_ready", req_ready, 0);

    // Randomized requests against the transaction-level model
    do_reset();
    m_mode = 0; m_rej = 0;
    for (int i = 0; i < 250; i++) begin
      rm = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      da = 1'($urandom_range(0, 1));
      dc = 1'($urandom_range(0, 1));
      ok = model_legal(m_mode, int'(rm), dc);
      lk = 1'b0;
      if (ok) begin
        m_mode = int'(rm);
        m_rej  = 0;
      end else begin
        m_rej = (m_rej < 15) ? m_rej + 1 : 15;
        if (m_rej == REJECT_LIMIT) begin
          lk = 1'b1;
          m_mode = 0;
        end
      end
      send_req(rm, da, dc, ok, 2'(m_mode), 4'(m_rej), lk);
      if (lk) begin
        do_reset();
        m_mode = 0; m_rej = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
